// File: rtl/sqm_pwm_pkg.sv
// sqm_pwm shared constants: volume/log widths, the 3 dB log table
// and a width helper.
package sqm_pwm_pkg;

    localparam int VOL_W = 4;
    localparam int LOG_W = 8;

    localparam logic [LOG_W-1:0] LOG_LUT [16] = '{
        8'd0,   8'd2,   8'd3,   8'd4,
        8'd6,   8'd8,   8'd11,  8'd16,
        8'd23,  8'd32,  8'd45,  8'd64,
        8'd90,  8'd128, 8'd181, 8'd255
    };

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/sqm_pwm_level.sv
// sqm_pwm level: log lookup per channel, mute masking, and a
// full-width arithmetic sum of all unmuted channels.
module sqm_pwm_level
    import sqm_pwm_pkg::*;
#(
    parameter int CHANNELS = 3
) (
    input  logic [VOL_W*CHANNELS-1:0]       din,
    input  logic [CHANNELS-1:0]             mute,
    output logic [LOG_W+clog2(CHANNELS)-1:0] sum
);

    localparam int SW = LOG_W + clog2(CHANNELS);

    // Sum the log-mapped volumes; the width never overflows by construction
    always_comb begin
        sum = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (!mute[i]) begin
                sum = sum + SW'(LOG_LUT[din[VOL_W*i +: VOL_W]]);
            end
        end
    end

endmodule

// File: rtl/sqm_pwm_mix.sv
// sqm_pwm_mix: multi-channel log DAC driver producing a 1-bit
// output in fixed-period PWM or first-order sigma-delta form.
module sqm_pwm_mix
    import sqm_pwm_pkg::*;
#(
    parameter int CHANNELS = 3,
    parameter int PW       = 10
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      en,
    input  logic                      mode,
    input  logic [VOL_W*CHANNELS-1:0] din,
    input  logic [CHANNELS-1:0]       mute,
    output logic                      y,
    output logic                      period_start,
    output logic [PW-1:0]             level
);

    localparam int SW = LOG_W + clog2(CHANNELS);

    if (CHANNELS < 1 || CHANNELS > 8) begin : g_ch_chk
        $error("sqm_pwm_mix: CHANNELS must be 1..8");
    end

    if (PW < SW) begin : g_pw_chk
        $error("sqm_pwm_mix: PW too small for CHANNELS");
    end

    logic [SW-1:0] sum;
    logic [PW-1:0] sum_ext;
    logic [PW-1:0] cnt;
    logic [PW-1:0] acc;
    logic [PW-1:0] cnt_nxt;
    logic [PW-1:0] lvl_nxt;
    logic [PW:0]   sd_sum;
    logic          wrap;
    logic          mode_q;

    sqm_pwm_level #(
        .CHANNELS (CHANNELS)
    ) u_level (
        .din  (din),
        .mute (mute),
        .sum  (sum)
    );

    // Next-state values: the PWM compare must see the post-update level
    always_comb begin
        sum_ext = PW'(sum);
        wrap    = &cnt;
        cnt_nxt = cnt + PW'(1);
        lvl_nxt = wrap ? sum_ext : level;
        sd_sum  = {1'b0, acc} + {1'b0, level};
    end

    // Mode switch, PWM counter/compare and sigma-delta accumulator
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mode_q       <= 1'b0;
            cnt          <= '0;
            acc          <= '0;
            level        <= '0;
            y            <= 1'b0;
            period_start <= 1'b0;
        end else if (!en) begin
            period_start <= 1'b0;
        end else if (mode != mode_q) begin
            mode_q       <= mode;
            cnt          <= '0;
            acc          <= '0;
            level        <= sum_ext;
            y            <= 1'b0;
            period_start <= 1'b0;
        end else if (!mode_q) begin
            cnt          <= cnt_nxt;
            level        <= lvl_nxt;
            period_start <= wrap;
            y            <= (cnt_nxt < lvl_nxt);
        end else begin
            level        <= sum_ext;
            acc          <= sd_sum[PW-1:0];
            y            <= sd_sum[PW];
            period_start <= 1'b0;
        end
    end

endmodule

// File: doc/sqm_pwm_mix.md
Name: sqm_pwm_mix

Overview:
- Parametrised multi-channel logarithmic DAC driver for SQMUSIC PSG outputs.
- Maps each 4-bit channel volume through a log table and sums the channels arithmetically, instead of OR-ing per-channel PWM outputs.
- Drives one 1-bit output in either fixed-period PWM mode or first-order sigma-delta mode; feeds the board-level RC filter.
- Inputs are latched only at safe points, so output pulses never glitch.

Parameters:
- CHANNELS, 3, number of 4-bit volume channels (1..8).
- PW, 10, PWM counter / sigma-delta accumulator width. Must satisfy PW >= 8 + clog2(CHANNELS); otherwise elaboration fails.

Ports:
- clk  in  1  system clock (>33 MHz).
- reset_n  in  1  asynchronous active-low reset.
- en  in  1  clock-enable tick; all state advances only on cycles with en=1.
- mode  in  1  0 = PWM, 1 = sigma-delta.
- din  in  4*CHANNELS  channel volumes; channel i is din[4i+3:4i].
- mute  in  CHANNELS  per-channel mute; 1 excludes the channel from the sum.
- y  out  1  DAC bit, registered.
- period_start  out  1  one-cycle pulse at each PWM period boundary.
- level  out  PW  currently latched sum, zero-extended.

Behaviour:
- Clock and reset: one clock, clk. reset_n is asynchronous and active-low.
- Reset values: y=0, period_start=0, level=0, counter=0, accumulator=0, mode_q=0.
- Log LUT, 8-bit, index 0..15, steps of about 3 dB: 0,2,3,4,6,8,11,16,23,32,45,64,90,128,181,255.
- Sum = sum over unmuted channels of LUT(din_i), computed combinationally at full width (8 + clog2(CHANNELS) bits), then zero-extended to PW bits.
- en=0: all registers hold, and period_start=0.
- Mode change: when en=1 and mode != mode_q:
  - mode_q <= mode; counter <= 0; accumulator <= 0; y <= 0; level <= sum; period_start <= 0.
  - A mode change takes priority over every other event in that cycle.
- PWM mode (mode_q=0), on each cycle with en=1:
  - counter <= counter+1, wrapping at 2^PW-1 -> 0.
  - When counter == 2^PW-1: level <= sum and period_start <= 1 in the next cycle. Otherwise period_start <= 0.
  - y <= (counter_next < level_next): the comparison uses the post-update values, so the new level applies from the first cycle of the new period.
  - Duty is level/2^PW. level=0 gives y constantly 0. 100% duty is unreachable by construction.
- Sigma-delta mode (mode_q=1), on each cycle with en=1:
  - level <= sum every en cycle.
  - {carry, acc} = acc + level, computed PW+1 bits wide. y <= carry; acc <= low PW bits.
  - period_start stays 0.
- Latency:
  - din to level: at most 2^PW en-cycles in PWM mode, 1 en-cycle in sigma-delta mode.
  - level to y: 1 cycle.
- din or mute changes mid-period in PWM mode have no effect until the next boundary.
- Reset asserted mid-period returns all outputs to reset values immediately (asynchronous). After release, PWM operation restarts with counter=0. The first latch of level happens at the first wrap; until then y=0.

Decomposition:
- Package sqm_pwm_pkg:
  - VOL_W=4 and LOG_W=8 constants.
  - The 16-entry LOG_LUT constant.
  - A width helper function, clog2.
- Sub-module sqm_pwm_level: combinational LUT lookup plus mute masking plus adder tree, parametrised by CHANNELS. The top module holds the counter, accumulator, mode logic and output registers.

Test Plan (CHANNELS=3, PW=10 unless noted):
1. Reset, mode=0, en=1, din A=15, B=0, C=0, mute=0: after the first wrap, level=255; y high exactly 255 of every 1024 cycles; period_start pulses every 1024 cycles.
2. All channels 15: level=765, y high 765/1024 cycles. All channels 0: level=0, y never high. Mute=3'b111 with all 15: y never high.
3. Mid-period change: A goes 15 -> 1 at counter=500. The current period still shows 255 high cycles; the next period shows 2 high cycles.
4. mode=1 with level sum 256 (A=13, B=13): y=1 on exactly every 4th en cycle, starting at the 4th en cycle after the mode switch; period_start stays 0.
5. en toggled 1-of-4 cycles with A=15: y duty is unchanged in en-cycles (255/1024). Outputs hold constant while en=0.
6. Assert reset_n low at counter=300 for 2 cycles: y, level and period_start go to 0 asynchronously. After release, y stays 0 for 1024 cycles, then resumes 255/1024.
